// File: rtl/tt_adder_pkg.sv
// rtl/tt_adder_pkg.sv - shared FSM state type and uio bit map for the serial wide adder
package tt_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_A = 2'd1,
        ST_LOAD_B = 2'd2,
        ST_OUT    = 2'd3
    } state_t;

    // uio_in bit positions
    localparam int UIO_IN_VALID  = 0;
    localparam int UIO_MODE      = 1;
    localparam int UIO_OUT_READY = 2;

    // uio_out bit positions
    localparam int UIO_IN_READY  = 3;
    localparam int UIO_OUT_VALID = 4;
    localparam int UIO_CY        = 5;
    localparam int UIO_SAT_HIT   = 6;
    localparam int UIO_ERR       = 7;

    // Upper five uio pins are outputs, lower three are inputs
    localparam logic [7:0] UIO_OE_VALUE = 8'b1111_1000;

endpackage

// File: rtl/tt_adder_byte_slice.sv
// rtl/tt_adder_byte_slice.sv - combinational 8-bit adder slice with carry in/out
//
// Ports:
//   a, b  : 8-bit operands (b is already inverted by the caller for subtraction)
//   cin   : carry in
//   sum   : 8-bit result
//   cout  : carry out
module tt_adder_byte_slice (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'h00, cin};

endmodule

// File: rtl/tt_um_wide_adder.sv
// rtl/tt_um_wide_adder.sv - byte-serial WIDTH-bit add/sub with idle timeout and optional saturation
//
// Operands arrive LSB first on ui_in (A bytes then B bytes); the result is
// returned LSB first on uo_out. A single byte slice is reused once per B byte.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : enable; when low all state freezes
//   ui_in      : operand byte
//   uo_out     : result byte (0 outside OUT)
//   uio_in     : [0] in_valid, [1] mode (0 add / 1 sub), [2] out_ready
//   uio_out    : [3] in_ready, [4] out_valid, [5] cy, [6] sat_hit, [7] err
//   uio_oe     : constant 8'b1111_1000
//
// Build option: define TT_ADDER_SAT_EN to saturate the result on carry/borrow.
module tt_um_wide_adder
    import tt_adder_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MAX_COUNT = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int N     = WIDTH / 8;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(MAX_COUNT + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_COUNT - 1);

    state_t state_q, state_d;

    logic [IDX_W-1:0]  idx;
    logic [N-1:0][7:0] a_buf;
    logic [N-1:0][7:0] r_buf;
    logic [CNT_W-1:0]  tcount;
    logic              mode_q;
    logic              c;
    logic              cy;
    logic              sat_hit;
    logic              err;

    logic       in_valid, out_ready, in_ready, out_valid;
    logic       accept, take, last, timeout;
    logic [7:0] b_op, sum;
    logic       cout, cy_fin;
    logic       unused_bits;

    assign in_valid  = uio_in[UIO_IN_VALID];
    assign out_ready = uio_in[UIO_OUT_READY];
    assign unused_bits = ^uio_in[7:3];

    assign in_ready  = (state_q != ST_OUT);
    assign out_valid = (state_q == ST_OUT);
    assign accept    = in_valid & in_ready;
    assign take      = out_valid & out_ready;
    assign last      = (idx == IDX_LAST);

    // Timeout only fires on a cycle with no accepted byte, so a byte arriving
    // on the final count always wins.
    assign timeout = ((state_q == ST_LOAD_A) || (state_q == ST_LOAD_B))
                     && !accept && (tcount == CNT_LAST);

    // Subtraction is A + ~B + 1; the +1 comes from c being preset to 1.
    assign b_op   = mode_q ? ~ui_in : ui_in;
    // Borrow is the inverse of the final carry when subtracting.
    assign cy_fin = mode_q ? ~cout : cout;

    tt_adder_byte_slice u_slice (
        .a    (a_buf[idx]),
        .b    (b_op),
        .cin  (c),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else if (ena) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = (N == 1) ? ST_LOAD_B : ST_LOAD_A;
            end
            ST_LOAD_A: begin
                if (accept && last) state_d = ST_LOAD_B;
                else if (timeout)   state_d = ST_IDLE;
            end
            ST_LOAD_B: begin
                if (accept && last) state_d = ST_OUT;
                else if (timeout)   state_d = ST_IDLE;
            end
            ST_OUT: begin
                if (take && last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            a_buf   <= '0;
            r_buf   <= '0;
            tcount  <= '0;
            mode_q  <= 1'b0;
            c       <= 1'b0;
            cy      <= 1'b0;
            sat_hit <= 1'b0;
            err     <= 1'b0;
        end else if (ena) begin
            if (accept || (state_d != state_q)) begin
                tcount <= '0;
            end else if ((state_q == ST_LOAD_A) || (state_q == ST_LOAD_B)) begin
                tcount <= tcount + CNT_W'(1);
            end

            if (timeout) begin
                a_buf <= '0;
                r_buf <= '0;
                idx   <= '0;
                c     <= 1'b0;
                err   <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (accept) begin
                            mode_q   <= uio_in[UIO_MODE];
                            c        <= uio_in[UIO_MODE];
                            a_buf    <= '0;
                            a_buf[0] <= ui_in;
                            r_buf    <= '0;
                            cy       <= 1'b0;
                            sat_hit  <= 1'b0;
                            err      <= 1'b0;
                            idx      <= (N > 1) ? IDX_W'(1) : '0;
                        end
                    end
                    ST_LOAD_A: begin
                        if (accept) begin
                            a_buf[idx] <= ui_in;
                            idx        <= last ? '0 : idx + IDX_W'(1);
                        end
                    end
                    ST_LOAD_B: begin
                        if (accept) begin
                            r_buf[idx] <= sum;
                            c          <= cout;
                            if (last) begin
                                cy  <= cy_fin;
                                idx <= '0;
`ifdef TT_ADDER_SAT_EN
                                if (cy_fin) begin
                                    r_buf   <= mode_q ? '0 : '1;
                                    sat_hit <= 1'b1;
                                end
`endif
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end
                    end
                    ST_OUT: begin
                        if (take) idx <= last ? '0 : idx + IDX_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign uo_out = (state_q == ST_OUT) ? r_buf[idx] : 8'h00;
    assign uio_oe = UIO_OE_VALUE;

    always_comb begin
        uio_out                = 8'h00;
        uio_out[UIO_IN_READY]  = in_ready;
        uio_out[UIO_OUT_VALID] = out_valid;
        uio_out[UIO_CY]        = cy;
        uio_out[UIO_SAT_HIT]   = sat_hit;
        uio_out[UIO_ERR]       = err;
    end

endmodule
